// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: mstatus/mtvec/mscratch/mepc/mcause plus 64-bit mcycle/minstret.
// Define CSR_COUNTERS_EN to build the counters; without it their addresses are unmapped.
module csr_regfile #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] MTVEC_RESET = '0
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic [11:0]      csr_addr_i,
   input  logic             csr_we_i,
   input  logic [WIDTH-1:0] csr_wdata_i,
   output logic [WIDTH-1:0] csr_data_o,
   output logic             csr_illegal_o,
   input  logic             retire_i,
   input  logic             trap_i,
   input  logic [WIDTH-1:0] trap_pc_i,
   input  logic [WIDTH-1:0] trap_cause_i,
   input  logic             mret_i,
   output logic [WIDTH-1:0] trap_vector_o,
   output logic [WIDTH-1:0] epc_o,
   output logic             mie_o
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [WIDTH-1:0] ALIGN_MASK = 'h3;

   logic             mie_q, mie_d;
   logic             mpie_q, mpie_d;
   logic [WIDTH-1:0] mtvec_q, mtvec_d;
   logic [WIDTH-1:0] mscratch_q, mscratch_d;
   logic [WIDTH-1:0] mepc_q, mepc_d;
   logic [WIDTH-1:0] mcause_q, mcause_d;
   logic             wr_en;

`ifdef CSR_COUNTERS_EN
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
   localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
   localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
   localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
   localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
   localparam logic [2*WIDTH-1:0] CNT_ONE = 1;

   logic [2*WIDTH-1:0] mcycle_q, mcycle_d;
   logic [2*WIDTH-1:0] minstret_q, minstret_d;
`else
   logic unused_retire;
   assign unused_retire = retire_i;
`endif

   always_comb begin
      csr_data_o    = '0;
      csr_illegal_o = 1'b0;
      case (csr_addr_i)
         ADDR_MSTATUS: begin
            csr_data_o[3] = mie_q;
            csr_data_o[7] = mpie_q;
         end
         ADDR_MTVEC:    csr_data_o = mtvec_q;
         ADDR_MSCRATCH: csr_data_o = mscratch_q;
         ADDR_MEPC:     csr_data_o = mepc_q;
         ADDR_MCAUSE:   csr_data_o = mcause_q;
`ifdef CSR_COUNTERS_EN
         ADDR_MCYCLE,   ADDR_CYCLE:    csr_data_o = mcycle_q[WIDTH-1:0];
         ADDR_MCYCLEH,  ADDR_CYCLEH:   csr_data_o = mcycle_q[2*WIDTH-1:WIDTH];
         ADDR_MINSTRET, ADDR_INSTRET:  csr_data_o = minstret_q[WIDTH-1:0];
         ADDR_MINSTRETH, ADDR_INSTRETH: csr_data_o = minstret_q[2*WIDTH-1:WIDTH];
`endif
         default: csr_illegal_o = 1'b1;
      endcase
      // addr[11:10] == 2'b11 is the architectural read-only CSR range
      if (csr_we_i && (csr_addr_i[11:10] == 2'b11)) csr_illegal_o = 1'b1;
   end

   assign wr_en = csr_we_i & ~csr_illegal_o & ~trap_i & ~mret_i;

   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
`ifdef CSR_COUNTERS_EN
      mcycle_d   = mcycle_q + CNT_ONE;
      minstret_d = minstret_q + (retire_i ? CNT_ONE : '0);
`endif
      if (trap_i) begin
         mepc_d   = trap_pc_i & ~ALIGN_MASK;
         mcause_d = trap_cause_i;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end else if (mret_i) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end else if (wr_en) begin
         case (csr_addr_i)
            ADDR_MSTATUS: begin
               mie_d  = csr_wdata_i[3];
               mpie_d = csr_wdata_i[7];
            end
            ADDR_MTVEC:     mtvec_d    = csr_wdata_i & ~ALIGN_MASK;
            ADDR_MSCRATCH:  mscratch_d = csr_wdata_i;
            ADDR_MEPC:      mepc_d     = csr_wdata_i & ~ALIGN_MASK;
            ADDR_MCAUSE:    mcause_d   = csr_wdata_i;
`ifdef CSR_COUNTERS_EN
            // a counter write replaces the increment for the whole counter that cycle
            ADDR_MCYCLE:    mcycle_d   = {mcycle_q[2*WIDTH-1:WIDTH], csr_wdata_i};
            ADDR_MCYCLEH:   mcycle_d   = {csr_wdata_i, mcycle_q[WIDTH-1:0]};
            ADDR_MINSTRET:  minstret_d = {minstret_q[2*WIDTH-1:WIDTH], csr_wdata_i};
            ADDR_MINSTRETH: minstret_d = {csr_wdata_i, minstret_q[WIDTH-1:0]};
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtvec_q    <= MTVEC_RESET & ~ALIGN_MASK;
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
`ifdef CSR_COUNTERS_EN
         mcycle_q   <= '0;
         minstret_q <= '0;
`endif
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
`ifdef CSR_COUNTERS_EN
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
`endif
      end
   end

   assign trap_vector_o = mtvec_q;
   assign epc_o         = mepc_q;
   assign mie_o         = mie_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: vector table for register/trap behaviour,
// hand sequences for reset release and the 64-bit counters (when CSR_COUNTERS_EN is set).
module tb_csr_regfile;

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic [11:0] csr_addr_i;
   logic        csr_we_i;
   logic [31:0] csr_wdata_i;
   logic [31:0] csr_data_o;
   logic        csr_illegal_o;
   logic        retire_i;
   logic        trap_i;
   logic [31:0] trap_pc_i;
   logic [31:0] trap_cause_i;
   logic        mret_i;
   logic [31:0] trap_vector_o;
   logic [31:0] epc_o;
   logic        mie_o;

   int checks   = 0;
   int failures = 0;

   csr_regfile #(.WIDTH(32), .MTVEC_RESET(32'h0000_0100)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .csr_addr_i(csr_addr_i), .csr_we_i(csr_we_i), .csr_wdata_i(csr_wdata_i),
      .csr_data_o(csr_data_o), .csr_illegal_o(csr_illegal_o),
      .retire_i(retire_i), .trap_i(trap_i), .trap_pc_i(trap_pc_i),
      .trap_cause_i(trap_cause_i), .mret_i(mret_i),
      .trap_vector_o(trap_vector_o), .epc_o(epc_o), .mie_o(mie_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        trap;
      logic        mret;
      logic [31:0] pc;
      logic [31:0] cause;
      logic [31:0] exp_data;
      logic        exp_ill;
      logic        exp_mie;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                      input logic trap, input logic mret, input logic [31:0] pc,
                      input logic [31:0] cause, input logic [31:0] exp_data,
                      input logic exp_ill, input logic exp_mie);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.trap = trap; v.mret = mret;
      v.pc = pc; v.cause = cause; v.exp_data = exp_data; v.exp_ill = exp_ill;
      v.exp_mie = exp_mie;
      vecs.push_back(v);
   endtask

   task automatic idle();
      csr_addr_i = 12'h000; csr_we_i = 1'b0; csr_wdata_i = '0; retire_i = 1'b0;
      trap_i = 1'b0; trap_pc_i = '0; trap_cause_i = '0; mret_i = 1'b0;
   endtask

   task automatic rd(input logic [11:0] addr);
      idle();
      csr_addr_i = addr;
   endtask

   task automatic wr(input logic [11:0] addr, input logic [31:0] data);
      idle();
      csr_addr_i = addr; csr_we_i = 1'b1; csr_wdata_i = data;
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [7:0] retire_pat;

      // reset held two edges while trap/write/retire are all asserted
      reset_n_i = 1'b0;
      wr(12'h340, 32'h0000_1111);
      trap_i = 1'b1; trap_pc_i = 32'h0000_0FFF; trap_cause_i = 32'h7; retire_i = 1'b1;
      cyc();
      chk("rst trap_vector", trap_vector_o, 32'h0000_0100);
      chk("rst epc", epc_o, 32'h0);
      chk("rst mie", {31'b0, mie_o}, 32'h0);
      cyc();
      reset_n_i = 1'b1;
      rd(12'hB00);
      #1;
`ifdef CSR_COUNTERS_EN
      chk("mcycle after release", csr_data_o, 32'h0);
      chk("mcycle ill", {31'b0, csr_illegal_o}, 32'h0);
      cyc();
      chk("mcycle next", csr_data_o, 32'h1);
`else
      chk("nocnt B00 data", csr_data_o, 32'h0);
      chk("nocnt B00 ill", {31'b0, csr_illegal_o}, 32'h1);
      cyc();
`endif

      //   we    addr     wdata          trap  mret  pc            cause         exp_data      ill   mie
      add(1'b0, 12'h305, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_0100, 1'b0, 1'b0);
      add(1'b0, 12'h300, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0,         1'b0, 1'b0);
      add(1'b0, 12'h341, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0,         1'b0, 1'b0);
      add(1'b0, 12'h342, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0,         1'b0, 1'b0);
      add(1'b0, 12'h340, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0,         1'b0, 1'b0);
      add(1'b1, 12'h340, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,         1'b0, 1'b0);
      add(1'b0, 12'h340, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0);
      add(1'b1, 12'h300, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,         1'b0, 1'b0);
      add(1'b0, 12'h300, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_0088, 1'b0, 1'b1);
      add(1'b1, 12'h305, 32'h0000_2003, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_0100, 1'b0, 1'b1);
      add(1'b0, 12'h305, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_2000, 1'b0, 1'b1);
      add(1'b1, 12'h7C0, 32'h0000_1234, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,         1'b1, 1'b1);
      add(1'b0, 12'h7C0, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0,         1'b1, 1'b1);
      add(1'b1, 12'h300, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_0088, 1'b0, 1'b1);
      add(1'b0, 12'h300, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0,         1'b0, 1'b0);
      add(1'b1, 12'h300, 32'h0000_0008, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,         1'b0, 1'b0);
      add(1'b0, 12'h300, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_0008, 1'b0, 1'b1);
      add(1'b1, 12'h341, 32'hFFFF_FFF0, 1'b1, 1'b0, 32'h0000_1236, 32'h8000_000B, 32'h0,       1'b0, 1'b1);
      add(1'b0, 12'h341, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_1234, 1'b0, 1'b0);
      add(1'b0, 12'h342, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h8000_000B, 1'b0, 1'b0);
      add(1'b0, 12'h300, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_0080, 1'b0, 1'b0);
      add(1'b1, 12'h300, 32'h0,         1'b0, 1'b1, 32'h0,        32'h0,        32'h0000_0080, 1'b0, 1'b0);
      add(1'b0, 12'h300, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_0088, 1'b0, 1'b1);
      add(1'b1, 12'h342, 32'h0000_0005, 1'b0, 1'b0, 32'h0,        32'h0,        32'h8000_000B, 1'b0, 1'b1);
      add(1'b0, 12'h342, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_0005, 1'b0, 1'b1);
      add(1'b0, 12'h300, 32'h0,         1'b1, 1'b1, 32'h0000_2000, 32'h3,       32'h0000_0088, 1'b0, 1'b1);
      add(1'b0, 12'h300, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_0080, 1'b0, 1'b0);
      add(1'b0, 12'h341, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_2000, 1'b0, 1'b0);
      add(1'b0, 12'h342, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_0003, 1'b0, 1'b0);
      add(1'b1, 12'h341, 32'h0000_5557, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_2000, 1'b0, 1'b0);
      add(1'b0, 12'h341, 32'h0,         1'b0, 1'b0, 32'h0,        32'h0,        32'h0000_5554, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         idle();
         csr_we_i = vecs[i].we; csr_addr_i = vecs[i].addr; csr_wdata_i = vecs[i].wdata;
         trap_i = vecs[i].trap; mret_i = vecs[i].mret;
         trap_pc_i = vecs[i].pc; trap_cause_i = vecs[i].cause;
         #1;
         chk($sformatf("vec%0d data", i), csr_data_o, vecs[i].exp_data);
         chk($sformatf("vec%0d illegal", i), {31'b0, csr_illegal_o}, {31'b0, vecs[i].exp_ill});
         chk($sformatf("vec%0d mie", i), {31'b0, mie_o}, {31'b0, vecs[i].exp_mie});
         cyc();
      end
      idle();
      chk("trap_vector_o", trap_vector_o, 32'h0000_2000);
      chk("epc_o", epc_o, 32'h0000_5554);

`ifdef CSR_COUNTERS_EN
      rd(12'hB02); #1; chk("minstret after reset", csr_data_o, 32'h0); cyc();
      wr(12'hB80, 32'h0000_0001); cyc();
      wr(12'hB00, 32'hFFFF_FFFE); cyc();
      rd(12'hB00); #1; chk("mcycle lo written", csr_data_o, 32'hFFFF_FFFE); cyc();
      rd(12'hC00); #1; chk("cycle mirror lo", csr_data_o, 32'hFFFF_FFFF); cyc();
      rd(12'hB80); #1; chk("mcycle carry hi", csr_data_o, 32'h0000_0002); cyc();
      wr(12'hC00, 32'h0000_0055); #1;
      chk("ro write illegal", {31'b0, csr_illegal_o}, 32'h1);
      chk("ro write data", csr_data_o, 32'h0000_0001);
      cyc();
      rd(12'hB00); #1; chk("ro write ignored", csr_data_o, 32'h0000_0002); cyc();
      rd(12'hC80); #1; chk("cycle mirror hi", csr_data_o, 32'h0000_0002); cyc();
      wr(12'hB80, 32'hFFFF_FFFF); cyc();
      wr(12'hB00, 32'hFFFF_FFFF); cyc();
      rd(12'hB80); #1; chk("mcycle all ones", csr_data_o, 32'hFFFF_FFFF); cyc();
      rd(12'hB80); #1; chk("mcycle wrap hi", csr_data_o, 32'h0); cyc();
      rd(12'hB00); #1; chk("mcycle wrap lo", csr_data_o, 32'h0000_0001); cyc();
      retire_pat = 8'b1100_1101;
      for (int k = 0; k < 8; k++) begin
         if (k == 0) wr(12'hB00, 32'h0);
         else idle();
         retire_i = retire_pat[k];
         cyc();
      end
      rd(12'hB02); #1; chk("minstret count", csr_data_o, 32'h0000_0005); cyc();
      rd(12'hC02); #1; chk("instret mirror", csr_data_o, 32'h0000_0005); cyc();
      wr(12'hB02, 32'h0000_0100); retire_i = 1'b1; cyc();
      rd(12'hB02); #1; chk("minstret write wins", csr_data_o, 32'h0000_0100); cyc();
      rd(12'hC82); #1; chk("instret hi", csr_data_o, 32'h0); cyc();
`else
      rd(12'hC02); #1;
      chk("nocnt C02 data", csr_data_o, 32'h0);
      chk("nocnt C02 ill", {31'b0, csr_illegal_o}, 32'h1);
      cyc();
      wr(12'hB82, 32'h1234_5678); retire_i = 1'b1; #1;
      chk("nocnt B82 wr ill", {31'b0, csr_illegal_o}, 32'h1);
      cyc();
      rd(12'hB82); #1; chk("nocnt B82 data", csr_data_o, 32'h0); cyc();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
